// File: rtl/delay_comp_seq_if.sv
// Result handshake between the delay-race sequencer and the digital core.
interface delay_comp_seq_if;
    logic       result_valid;
    logic       result_ready;
    logic       result;
    logic [3:0] vote_count;
    logic       timeout;

    // Sequencer side produces the decision, core side accepts it
    modport master (
        output result_valid,
        output result,
        output vote_count,
        output timeout,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result,
        input  vote_count,
        input  timeout,
        output result_ready
    );
endinterface

// File: rtl/delay_comp_seq.sv
// Delay-race sequencer: launches race edges, waits for the comparator done,
// samples its decision TRIALS times and returns the majority vote.
module delay_comp_seq #(
    parameter int unsigned TRIALS         = 5,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES  = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    output logic launch_o,
    input  logic cmp_done_i,
    input  logic cmp_y_i,
    output logic output_enable_o,
    output logic busy_o,
    delay_comp_seq_if.master res_if
);
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_ENABLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_RTZ    = 3'd4;
    localparam logic [2:0] S_OUTPUT = 3'd5;

    logic [2:0]    state_q,    state_d;
    logic [CW-1:0] trial_q,    trial_d;
    logic [CW-1:0] vote_q,     vote_d;
    logic [TW-1:0] timer_q,    timer_d;
    logic          abort_q,    abort_d;
    logic          launch_q,   launch_d;
    logic          oe_q,       oe_d;
    logic          busy_q,     busy_d;
    logic          valid_q,    valid_d;
    logic          result_q,   result_d;
    logic [CW-1:0] vote_cnt_q, vote_cnt_d;
    logic          timeout_q,  timeout_d;

    logic done_meta_q, done_s_q;
    logic y_meta_q,    y_s_q;

    // Two-flop synchronizers for the asynchronous comparator outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_meta_q <= 1'b1;
            done_s_q    <= 1'b1;
            y_meta_q    <= 1'b0;
            y_s_q       <= 1'b0;
        end else begin
            done_meta_q <= cmp_done_i;
            done_s_q    <= done_meta_q;
            y_meta_q    <= cmp_y_i;
            y_s_q       <= y_meta_q;
        end
    end

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d    = state_q;
        trial_d    = trial_q;
        vote_d     = vote_q;
        timer_d    = timer_q;
        abort_d    = abort_q;
        result_d   = result_q;
        vote_cnt_d = vote_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LAUNCH;
                    trial_d = '0;
                    vote_d  = '0;
                    timer_d = '0;
                    abort_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                if (!done_s_q) begin
                    state_d = S_ENABLE;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_RTZ;
                    timer_d = '0;
                    abort_d = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ENABLE: begin
                // Two cycles cover the Y synchronizer latency after enabling
                if (timer_q == TW'(1)) begin
                    state_d = S_SAMPLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_SAMPLE: begin
                if (y_s_q && (vote_q != CW'(TRIALS))) begin
                    vote_d = vote_q + CW'(1);
                end
                if (trial_q != CW'(TRIALS)) begin
                    trial_d = trial_q + CW'(1);
                end
                state_d = S_RTZ;
            end
            S_RTZ: begin
                // Settle count restarts whenever done is still low
                if (!done_s_q) begin
                    timer_d = '0;
                end else if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
                    timer_d = '0;
                    if (abort_q || (trial_q == CW'(TRIALS))) begin
                        state_d    = S_OUTPUT;
                        result_d   = !abort_q && (vote_q > CW'(TRIALS / 2));
                        vote_cnt_d = vote_q;
                        timeout_d  = abort_q;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OUTPUT: begin
                if (valid_q && res_if.result_ready) begin
                    state_d    = S_IDLE;
                    result_d   = 1'b0;
                    vote_cnt_d = '0;
                    timeout_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        launch_d = (state_d == S_LAUNCH) || (state_d == S_ENABLE) || (state_d == S_SAMPLE);
        oe_d     = (state_d == S_ENABLE) || (state_d == S_SAMPLE);
        busy_d   = (state_d != S_IDLE);
        valid_d  = (state_d == S_OUTPUT);
    end

    // State, counters and outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            trial_q    <= '0;
            vote_q     <= '0;
            timer_q    <= '0;
            abort_q    <= 1'b0;
            launch_q   <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= 1'b0;
            vote_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            trial_q    <= trial_d;
            vote_q     <= vote_d;
            timer_q    <= timer_d;
            abort_q    <= abort_d;
            launch_q   <= launch_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            vote_cnt_q <= vote_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign launch_o            = launch_q;
    assign output_enable_o     = oe_q;
    assign busy_o              = busy_q;
    assign res_if.result_valid = valid_q;
    assign res_if.result       = result_q;
    assign res_if.vote_count   = vote_cnt_q;
    assign res_if.timeout      = timeout_q;
endmodule

// File: tb/tb_delay_comp_seq.sv
// Bench for delay_comp_seq: comparator model driven from Launch plus a
// behavioural expectation of every conversion's outcome and edge timing.
module tb_delay_comp_seq;
    localparam int TRIALS = 5;
    localparam int TMO    = 16;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i, start_i, cmp_done_i, cmp_y_i;
    logic launch_o, oe_o, busy_o;

    delay_comp_seq_if rif ();

    delay_comp_seq #(
        .TRIALS(TRIALS), .TIMEOUT_CYCLES(TMO), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .start_i(start_i),
        .launch_o(launch_o),
        .cmp_done_i(cmp_done_i),
        .cmp_y_i(cmp_y_i),
        .output_enable_o(oe_o),
        .busy_o(busy_o),
        .res_if(rif)
    );

    // Stimulus-owned configuration and expectations
    int          cfg_dd, cfg_hold;
    logic [15:0] cfg_votes;
    int          lit_res, lit_vote, lit_to;
    int          exp_vote, exp_launches;
    bit          exp_result, exp_timeout;
    int          convs_req;
    bit          all_done;

    // Compare-process-owned state
    int total, bad;
    int cyc, convs_done, trial_idx, launches_seen;
    int rise_cyc, oe_rise_cyc, done_fall_at, done_rise_at, done_rise_cyc, busy_cnt;
    bit launch_prev, oe_prev, prev_valid, first_valid, final_done;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Comparator model and per-cycle checks, sampled 1ns after each rising edge
    initial begin : compare
        cmp_done_i = 1'b1; cmp_y_i = 1'b0;
        done_fall_at = -1; done_rise_at = -1; done_rise_cyc = -1;
        first_valid = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (reset_i) begin
                chk("rst_launch",  int'(launch_o), 0);
                chk("rst_oe",      int'(oe_o), 0);
                chk("rst_busy",    int'(busy_o), 0);
                chk("rst_valid",   int'(rif.result_valid), 0);
                chk("rst_result",  int'(rif.result), 0);
                chk("rst_vote",    int'(rif.vote_count), 0);
                chk("rst_timeout", int'(rif.timeout), 0);
                cmp_done_i = 1'b1; cmp_y_i = 1'b0;
                trial_idx = 0; launches_seen = 0; busy_cnt = 0;
                done_fall_at = -1; done_rise_at = -1; done_rise_cyc = -1;
                launch_prev = 1'b0; oe_prev = 1'b0; prev_valid = 1'b0; first_valid = 1'b1;
            end else begin
                if (prev_valid && rif.result_ready) begin
                    chk("hs_valid_clr", int'(rif.result_valid), 0);
                    chk("hs_busy_clr",  int'(busy_o), 0);
                    convs_done++;
                    trial_idx = 0; launches_seen = 0; done_rise_cyc = -1; first_valid = 1'b1;
                end
                if (launch_o && !launch_prev) begin
                    if (done_rise_cyc >= 0) chk("rtz_gap", cyc - done_rise_cyc, 2 + SETTLE);
                    done_rise_cyc = -1;
                    cmp_y_i = (trial_idx < 16) ? cfg_votes[trial_idx] : 1'b0;
                    trial_idx++; launches_seen++;
                    rise_cyc = cyc;
                    done_fall_at = (cfg_dd >= 0) ? cyc + cfg_dd : -1;
                end
                if (!launch_o && launch_prev) begin
                    chk("launch_width", cyc - rise_cyc, (cfg_dd < 0) ? TMO : cfg_dd + 6);
                    if (cfg_dd >= 0) done_rise_at = cyc + cfg_hold;
                end
                if (oe_o && !oe_prev) begin
                    chk("oe_delay", cyc - rise_cyc, cfg_dd + 3);
                    oe_rise_cyc = cyc;
                end
                if (!oe_o && oe_prev) chk("oe_width", cyc - oe_rise_cyc, 3);
                if (cyc == done_fall_at) cmp_done_i = 1'b0;
                if (cyc == done_rise_at) begin
                    cmp_done_i = 1'b1;
                    done_rise_cyc = cyc;
                end
                chk("oe_without_launch", int'(oe_o && !launch_o), 0);
                if (launch_o || rif.result_valid) chk("busy_active", int'(busy_o), 1);
                if (rif.result_valid) begin
                    if (first_valid) begin
                        chk("launch_count", launches_seen, exp_launches);
                        if (lit_res >= 0)  chk("lit_result",  int'(rif.result), lit_res);
                        if (lit_vote >= 0) chk("lit_vote",    int'(rif.vote_count), lit_vote);
                        if (lit_to >= 0)   chk("lit_timeout", int'(rif.timeout), lit_to);
                        first_valid = 1'b0;
                    end
                    chk("result",     int'(rif.result), int'(exp_result));
                    chk("vote_count", int'(rif.vote_count), exp_vote);
                    chk("timeout",    int'(rif.timeout), int'(exp_timeout));
                end else begin
                    chk("idle_result_zero", int'({rif.result, rif.vote_count, rif.timeout}), 0);
                end
                if (busy_o && !rif.result_valid) busy_cnt++; else busy_cnt = 0;
                if (busy_cnt == 600) chk("valid_wait_expired", 0, 1);
                launch_prev = launch_o; oe_prev = oe_o; prev_valid = rif.result_valid;
            end
            if (all_done && !final_done) begin
                chk("conv_count", convs_done, convs_req);
                final_done = 1'b1;
            end
        end
    end

    task automatic set_cfg(input int dd, input int hold, input logic [15:0] v,
                           input int lr, input int lv, input int lt);
        int s;
        cfg_dd = dd; cfg_hold = hold; cfg_votes = v;
        lit_res = lr; lit_vote = lv; lit_to = lt;
        s = 0;
        for (int i = 0; i < TRIALS; i++) s += int'(v[i]);
        exp_timeout  = (dd < 0);
        exp_vote     = (dd < 0) ? 0 : s;
        exp_result   = (dd >= 0) && (s > TRIALS / 2);
        exp_launches = (dd < 0) ? 1 : TRIALS;
    endtask

    task automatic run_conv(input int dd, input int hold, input logic [15:0] v, input int rwait,
                            input bit spam, input int lr, input int lv, input int lt);
        int n;
        set_cfg(dd, hold, v, lr, lv, lt);
        convs_req++;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        n = 0;
        while (!rif.result_valid && n < 700) begin
            @(negedge clk); n++;
        end
        for (int i = 0; i < rwait; i++) begin
            start_i = spam && (i % 2 == 1);
            @(negedge clk);
        end
        start_i = 1'b0;
        rif.result_ready = 1'b1;
        @(negedge clk);
        rif.result_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_in_trial3();
        int n;
        set_cfg(3, 1, 16'h001F, -1, -1, -1);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        n = 0;
        while (!(trial_idx == 3 && oe_o) && n < 500) begin
            @(negedge clk); n++;
        end
        reset_i = 1'b1;
        @(negedge clk); reset_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        reset_i = 1'b1; start_i = 1'b0; rif.result_ready = 1'b0;
        set_cfg(3, 0, 16'h0000, -1, -1, -1);
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (2) @(negedge clk);

        // votes 1,1,0,1,0 and 0,0,1,0,1 (trial 0 in bit 0)
        run_conv(3, 0, 16'h000B, 3, 1'b0, 1, 3, 0);
        run_conv(3, 0, 16'h0014, 0, 1'b0, 0, 2, 0);
        // done never falls: abort after the launch timeout
        run_conv(-1, 0, 16'h001F, 2, 1'b0, 0, 0, 1);
        // consumer stalls 10 cycles while Start is pulsed
        run_conv(2, 1, 16'h0017, 10, 1'b1, 1, 4, 0);
        // reset mid-conversion, then a full conversion
        reset_in_trial3();
        run_conv(3, 0, 16'h0001, 1, 1'b0, 0, 1, 0);
        // done held low long after launch drops
        run_conv(2, 7, 16'h001F, 1, 1'b0, 1, 5, 0);

        for (int k = 0; k < 8; k++) begin
            run_conv(int'($urandom_range(0, 6)), int'($urandom_range(0, 8)), 16'($urandom),
                     int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1, -1, -1);
        end

        all_done = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
